// File: rtl/sna_pkg.sv
// Shared types and constants for the serial nibble adder controller.
package sna_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } sna_state_e;

  // At least one bit, even for a single-nibble build.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_nibble_add_ctrl_if.sv
// Operand/result handshake bundle for serial_nibble_add_ctrl.
// Carries out_ovf only when SNA_SIGNED_OVF_EN is defined.
interface serial_nibble_add_ctrl_if
  import sna_pkg::*;
#(
  parameter int NIBBLES = 4
);

  localparam int W = SLICE_W * NIBBLES;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         busy;
`ifdef SNA_SIGNED_OVF_EN
  logic         out_ovf;
`endif

`ifdef SNA_SIGNED_OVF_EN
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy, out_ovf
  );
`else
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, busy
  );

  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, busy
  );
`endif

endinterface

// File: rtl/nibble_add4.sv
// 4-bit ripple-carry slice built from full-adder cells.
module nibble_add4
  import sna_pkg::*;
(
  output logic               cout,
  output logic [SLICE_W-1:0] sum,
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin
);

  logic [SLICE_W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < SLICE_W; i++) begin : g_fa
    logic p;
    assign p      = a[i] ^ b[i];
    assign sum[i] = p ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & p);
  end

  assign cout = c[SLICE_W];

endmodule

// File: rtl/serial_nibble_add_ctrl.sv
// Multi-word adder sequencing one 4-bit slice, LS nibble first.
// Optional signed overflow output: define SNA_SIGNED_OVF_EN.
module serial_nibble_add_ctrl
  import sna_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_nibble_add_ctrl_if.slave bus
);

  localparam int W  = SLICE_W * NIBBLES;
  localparam int IW = idx_width(NIBBLES);
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  sna_state_e   state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic         carry_q, carry_d;
  logic [W-1:0] a_sh_q, a_sh_d;
  logic [W-1:0] b_sh_q, b_sh_d;
  logic [W-1:0] res_q, res_d;
  logic [W-1:0] out_sum_q, out_sum_d;
  logic         out_cout_q, out_cout_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  logic         in_ready_q, in_ready_d;
`ifdef SNA_SIGNED_OVF_EN
  logic         a_msb_q, a_msb_d;
  logic         b_msb_q, b_msb_d;
  logic         ovf_q, ovf_d;
`endif

  logic [SLICE_W-1:0] s_sum;
  logic               s_cout;

  nibble_add4 u_slice (
    .cout (s_cout),
    .sum  (s_sum),
    .a    (a_sh_q[SLICE_W-1:0]),
    .b    (b_sh_q[SLICE_W-1:0]),
    .cin  (carry_q)
  );

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    carry_d    = carry_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    res_d      = res_q;
    out_sum_d  = out_sum_q;
    out_cout_d = out_cout_q;
`ifdef SNA_SIGNED_OVF_EN
    a_msb_d    = a_msb_q;
    b_msb_d    = b_msb_q;
    ovf_d      = ovf_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          a_sh_d  = bus.in_a;
          b_sh_d  = bus.in_b;
          carry_d = bus.in_cin;
          idx_d   = '0;
          state_d = ST_RUN;
`ifdef SNA_SIGNED_OVF_EN
          a_msb_d = bus.in_a[W-1];
          b_msb_d = bus.in_b[W-1];
`endif
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh_q >> SLICE_W;
        b_sh_d = b_sh_q >> SLICE_W;
        res_d  = res_q >> SLICE_W;
        res_d[W-1 -: SLICE_W] = s_sum;
        carry_d = s_cout;
        if (idx_q == LAST) begin
          state_d    = ST_DONE;
          out_sum_d  = res_d;
          out_cout_d = s_cout;
`ifdef SNA_SIGNED_OVF_EN
          ovf_d = (a_msb_q == b_msb_q) &&
                  (s_sum[SLICE_W-1] != a_msb_q);
`endif
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    out_valid_d = (state_d == ST_DONE);
    busy_d      = (state_d != ST_IDLE);
    in_ready_d  = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      in_ready_q  <= 1'b1;
`ifdef SNA_SIGNED_OVF_EN
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      res_q       <= res_d;
      out_sum_q   <= out_sum_d;
      out_cout_q  <= out_cout_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      in_ready_q  <= in_ready_d;
`ifdef SNA_SIGNED_OVF_EN
      a_msb_q     <= a_msb_d;
      b_msb_q     <= b_msb_d;
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_cout  = out_cout_q;
  assign bus.busy      = busy_q;
`ifdef SNA_SIGNED_OVF_EN
  assign bus.out_ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_nibble_add_ctrl.sv
// Self-checking bench for serial_nibble_add_ctrl (NIBBLES=4).
module tb_serial_nibble_add_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  serial_nibble_add_ctrl_if #(.NIBBLES(N)) bus ();

  serial_nibble_add_ctrl #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int npass = 0;
  int ntot  = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic logic get_ovf();
`ifdef SNA_SIGNED_OVF_EN
    return bus.out_ovf;
`else
    return 1'b0;
`endif
  endfunction

  // Reference: plain wide addition and the two's-complement rule.
  function automatic logic [W:0] ref_add(input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic cin);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  endfunction

  function automatic logic ref_ovf(input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic [W-1:0] s);
    return (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
  endfunction

  task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!bus.in_ready) chk("accept_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = cin;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    bus.in_cin   = 1'b0;
  endtask

  // lat counts rising edges including the accepting one.
  task automatic wait_result(output logic [W-1:0] sum, output logic cout,
                             output logic ovf, output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) chk("result_timeout", 32'd0, 32'd1);
    sum  = bus.out_sum;
    cout = bus.out_cout;
    ovf  = get_ovf();
  endtask

  task automatic handshake();
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input int hold,
                        output logic [W-1:0] sum, output logic cout,
                        output logic ovf, output int lat,
                        output bit stable);
    accept(a, b, cin);
    wait_result(sum, cout, ovf, lat);
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      if (!bus.out_valid || bus.out_sum !== sum ||
          bus.out_cout !== cout) stable = 1'b0;
    end
    handshake();
  endtask

  initial begin
    logic [W-1:0] s;
    logic         c;
    logic         o;
    logic [W:0]   r;
    int           lat;
    bit           st;
    bit           quiet;

    tbl[0] = '{16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
    tbl[3] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_cin    = 1'b0;
    bus.out_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_out_cout", 32'(bus.out_cout), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus.busy || !bus.in_ready ||
          bus.out_sum !== '0) quiet = 1'b0;
    end
    chk("idle_quiet", 32'(quiet), 32'd1);

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, 0, s, c, o, lat, st);
      chk($sformatf("tbl%0d_sum", i), 32'(s), 32'(tbl[i].sum));
      chk($sformatf("tbl%0d_cout", i), 32'(c), 32'(tbl[i].cout));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), 32'(N + 1));
`ifdef SNA_SIGNED_OVF_EN
      chk($sformatf("tbl%0d_ovf", i), 32'(o), 32'(tbl[i].ovf));
`endif
    end

    run_op(16'h1111, 16'h2222, 1'b0, 10, s, c, o, lat, st);
    chk("bp_stable", 32'(st), 32'd1);
    chk("bp_sum", 32'(s), 32'h3333);
    chk("bp_valid_drop", 32'(bus.out_valid), 32'd0);
    chk("bp_busy_drop", 32'(bus.busy), 32'd0);

    accept(16'h0001, 16'h0002, 1'b0);
    @(posedge clk);
    #1;
    chk("run_in_ready", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_a     = 16'hAAAA;
    bus.in_b     = 16'hAAAA;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    wait_result(s, c, o, lat);
    chk("ign_sum", 32'(s), 32'h0003);
    handshake();
    repeat (2) @(posedge clk);
    #1;
    chk("ign_no_extra", 32'(bus.busy), 32'd0);
    run_op(16'h0010, 16'h0020, 1'b0, 0, s, c, o, lat, st);
    chk("ign_next_sum", 32'(s), 32'h0030);

    accept(16'h00FF, 16'h0001, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mrst_out_sum", 32'(bus.out_sum), 32'd0);
    chk("mrst_busy", 32'(bus.busy), 32'd0);
    chk("mrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (bus.out_valid || bus.busy) quiet = 1'b0;
    end
    chk("mrst_no_result", 32'(quiet), 32'd1);
    run_op(16'h0005, 16'h0006, 1'b0, 0, s, c, o, lat, st);
    chk("mrst_next_sum", 32'(s), 32'h000B);
    chk("mrst_next_lat", 32'(lat), 32'(N + 1));

    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom);
      if (i < 4) begin
        ra = (i % 2 == 0) ? 16'hFFFF : 16'h8000;
        rb = (i < 2) ? 16'hFFFF : 16'h7FFF;
      end
      r = ref_add(ra, rb, rc);
      run_op(ra, rb, rc, int'($urandom_range(0, 2)), s, c, o, lat, st);
      chk($sformatf("rnd%0d_sum", i), 32'(s), 32'(r[W-1:0]));
      chk($sformatf("rnd%0d_cout", i), 32'(c), 32'(r[W]));
`ifdef SNA_SIGNED_OVF_EN
      chk($sformatf("rnd%0d_ovf", i), 32'(o),
          32'(ref_ovf(ra, rb, r[W-1:0])));
`endif
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
